cp0_excctl: RTL and testbench
=============================

Name: cp0_excctl

Overview:
- Coprocessor-0 exception controller for the pipelined MIPS core.
- Sits at the M stage and is the responder for the decoder's branch and eret signals:
  - records the victim PC, the delay-slot flag and the cause when an exception or interrupt is taken;
  - restores EPC and clears EXL on eret;
  - serves mfc0/mtc0 accesses to SR, Cause, EPC and PRId.
- Outputs drive PC redirection and pipeline flush.

Parameters:
- PRID, 32'h2017_1205, read-only value returned for register 15.
- HANDLER, 32'h0000_4180, exception entry address driven on handler_pc.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  mtc0 write enable (M stage).
- addr  input  5  CP0 register number for read/write.
- wdata  input  32  mtc0 write data.
- rdata  output  32  mfc0 read data, combinational from addr.
- pc_m  input  32  PC of the M-stage instruction.
- bd_m  input  1  M-stage instruction sits in a branch delay slot (previous instruction asserted br).
- exccode_m  input  5  synchronous exception code of the M-stage instruction; 0 = none.
- badaddr_m  input  32  faulting address for AdEL/AdES; used only under the optional feature.
- hwint  input  6  external interrupt lines, level sensitive.
- eret_m  input  1  eret in M stage.
- exc_req  output  1  take exception/interrupt this cycle (flush F/D/E/M, redirect to handler_pc).
- handler_pc  output  32  constant HANDLER.
- epc_out  output  32  current EPC, redirect target on eret.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. On reset:
  - SR = 0 (IM = 0, EXL = 0, IE = 0).
  - Cause = 0.
  - EPC = 0.
  - Outputs follow, so exc_req = 0 and epc_out = 0.
- Register map:
  - 12 SR: IM[15:10], EXL[1], IE[0]; other bits read 0.
  - 13 Cause: BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - 14 EPC: bits[1:0] always 0.
  - 15 PRId = PRID.
  - Any other addr reads 0.
- Interrupt condition: int_req = (|(hwint & SR.IM)) & SR.IE & ~SR.EXL.
- Exception condition: exc_exc = (exccode_m != 0) & ~SR.EXL.
- exc_req = int_req | exc_exc. Combinational in the same cycle as inputs; no added latency.
- Cause.IP <= hwint every cycle, including cycles with exc_req, independent of masking.
- On exc_req, at the next edge:
  - EXL <= 1.
  - Cause.BD <= bd_m.
  - Cause.ExcCode <= int_req ? 0 : exccode_m. Interrupt beats a simultaneous synchronous exception.
  - EPC <= bd_m ? {pc_m[31:2],2'b00} - 4 : {pc_m[31:2],2'b00}.
- On eret_m with no exc_req: EXL <= 0 at the next edge. epc_out is valid the same cycle for redirect.
- mtc0 (we, no exc_req, no eret_m):
  - addr 12 writes IM, EXL and IE from wdata.
  - addr 14 writes EPC with bits[1:0] forced to 0.
  - Cause and PRId are read-only; writes are ignored.
- Priority, highest first: reset, exc_req, eret_m, we. A lower-priority update in the same cycle is discarded entirely. A write of 0 to SR while exc_req is high is lost.
- Nesting: no new request is accepted while EXL = 1. Level-held interrupts fire on the first cycle after EXL clears, if still asserted and unmasked.
- Read during write: rdata shows the old value in the write cycle and the new value from the next cycle. No internal bypass; the hazard unit stalls.
- PC wrap: with bd_m = 1 and pc_m = 0, EPC = 32'hFFFF_FFFC (modular).

Optional Feature:
- Macro: CP0_BADVADDR_EN.
- Defined:
  - Adds register 8 BadVAddr, read-only, reset 0.
  - On exc_req with ~int_req and exccode_m equal to 4 (AdEL) or 5 (AdES), BadVAddr <= badaddr_m.
  - Otherwise BadVAddr holds.
- Undefined:
  - No register; addr 8 reads 0.
  - badaddr_m is ignored.

Test Plan:
- Reset then read addr 15 -> rdata = 32'h2017_1205; addr 12/13/14 read 0.
- mtc0 SR = 32'h0000_0401, hwint = 6'b000001, pc_m = 32'h0000_3010, bd_m = 0 -> exc_req = 1 same cycle; next cycle EPC = 32'h0000_3010, ExcCode = 0, EXL = 1, exc_req = 0 while hwint is held.
- exccode_m = 10, pc_m = 32'h0000_3024, bd_m = 1 -> EPC = 32'h0000_3020, Cause.BD = 1, ExcCode = 10.
- With EXL = 1, assert eret_m -> epc_out = EPC that cycle; next cycle EXL = 0. With hwint still asserted, exc_req rises in that same next cycle.
- Same cycle: we to SR with wdata = 0, and exccode_m = 12 with EXL = 0 -> exception taken (EXL = 1, ExcCode = 12); SR write discarded.
- With CP0_BADVADDR_EN: exccode_m = 4, badaddr_m = 32'h0000_1003 -> addr 8 reads 32'h0000_1003. Without the macro, addr 8 reads 0.

Source files
------------

// File: rtl/cp0_excctl.sv
// CP0 exception controller at the M stage: SR/Cause/EPC/PRId, exception and interrupt entry, eret.
// Optional BadVAddr register (addr 8) is built only when CP0_BADVADDR_EN is defined.
module cp0_excctl #(
    parameter logic [31:0] PRID    = 32'h2017_1205,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exccode_m,
    input  logic [31:0] badaddr_m,
    input  logic [5:0]  hwint,
    input  logic        eret_m,
    output logic        exc_req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_SR       = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;
    localparam logic [4:0] EXC_ADEL      = 5'd4;
    localparam logic [4:0] EXC_ADES      = 5'd5;

    logic [5:0]  sr_im_reg;
    logic        sr_exl_reg;
    logic        sr_ie_reg;
    logic        cause_bd_reg;
    logic [5:0]  cause_ip_reg;
    logic [4:0]  cause_exc_reg;
    logic [29:0] epc_reg;          // EPC[31:2]; the low two bits are always zero

    logic [5:0]  pending;
    logic        int_req;
    logic        exc_exc;
    logic [31:0] pc_aligned;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] epc_word;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_pending
            assign pending[gi] = hwint[gi] & sr_im_reg[gi];
        end
    endgenerate

    assign int_req = (|pending) & sr_ie_reg & ~sr_exl_reg;
    assign exc_exc = (exccode_m != 5'd0) & ~sr_exl_reg;
    assign exc_req = int_req | exc_exc;

    // A delay-slot victim restarts at the branch, one word earlier; wraps modulo 2^32.
    assign pc_aligned = {pc_m[31:2], 2'b00};
    assign epc_next   = bd_m ? (pc_aligned - 32'd4) : pc_aligned;

    assign sr_word    = {16'h0000, sr_im_reg, 8'h00, sr_exl_reg, sr_ie_reg};
    assign cause_word = {cause_bd_reg, 15'h0000, cause_ip_reg, 3'b000, cause_exc_reg, 2'b00};
    assign epc_word   = {epc_reg, 2'b00};

    assign handler_pc = HANDLER;
    assign epc_out    = epc_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_reg     <= 6'd0;
            sr_exl_reg    <= 1'b0;
            sr_ie_reg     <= 1'b0;
            cause_bd_reg  <= 1'b0;
            cause_ip_reg  <= 6'd0;
            cause_exc_reg <= 5'd0;
            epc_reg       <= 30'd0;
        end else begin
            cause_ip_reg <= hwint;
            if (exc_req) begin
                sr_exl_reg    <= 1'b1;
                cause_bd_reg  <= bd_m;
                cause_exc_reg <= int_req ? 5'd0 : exccode_m;
                epc_reg       <= epc_next[31:2];
            end else if (eret_m) begin
                sr_exl_reg <= 1'b0;
            end else if (we) begin
                if (addr == ADDR_SR) begin
                    sr_im_reg  <= wdata[15:10];
                    sr_exl_reg <= wdata[1];
                    sr_ie_reg  <= wdata[0];
                end else if (addr == ADDR_EPC) begin
                    epc_reg <= wdata[31:2];
                end
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_reg <= 32'd0;
        end else if (exc_req && !int_req &&
                     (exccode_m == EXC_ADEL || exccode_m == EXC_ADES)) begin
            badvaddr_reg <= badaddr_m;
        end
    end
`else
    logic unused_badaddr;
    assign unused_badaddr = ^badaddr_m;
`endif

    always_comb begin
        rdata = 32'd0;
        case (addr)
`ifdef CP0_BADVADDR_EN
            ADDR_BADVADDR: rdata = badvaddr_reg;
`endif
            ADDR_SR:       rdata = sr_word;
            ADDR_CAUSE:    rdata = cause_word;
            ADDR_EPC:      rdata = epc_word;
            ADDR_PRID:     rdata = PRID;
            default:       rdata = 32'd0;
        endcase
    end

`ifndef CP0_BADVADDR_EN
    logic unused_addr8;
    assign unused_addr8 = (ADDR_BADVADDR == 5'd0) | (EXC_ADEL == 5'd0) | (EXC_ADES == 5'd0);
`endif

endmodule

// File: tb/tb_cp0_excctl.sv
// Bench for cp0_excctl: word-level CP0 model checked every cycle plus literal spot checks.
module tb_cp0_excctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exccode_m;
    logic [31:0] badaddr_m;
    logic [5:0]  hwint;
    logic        eret_m;
    logic        exc_req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state held as architectural register words.
    logic [31:0] m_sr, m_cause, m_epc, m_badv;
    bit          model_valid = 0;

    cp0_excctl dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .pc_m(pc_m), .bd_m(bd_m), .exccode_m(exccode_m), .badaddr_m(badaddr_m),
        .hwint(hwint), .eret_m(eret_m), .exc_req(exc_req), .handler_pc(handler_pc),
        .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic m_int();
        return ((hwint & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || ((exccode_m != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_rdata();
        case (addr)
`ifdef CP0_BADVADDR_EN
            5'd8:  return m_badv;
`endif
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return 32'h2017_1205;
            default: return 32'd0;
        endcase
    endfunction

    task automatic settle();
        #1;
        if (model_valid) begin
            check("exc_req", {31'd0, exc_req}, {31'd0, m_req()});
            check("epc_out", epc_out, m_epc);
            check("handler_pc", handler_pc, 32'h0000_4180);
            check("rdata", rdata, m_rdata());
        end
    endtask

    task automatic adv();
        logic i, r;
        @(posedge clk);
        i = m_int();
        r = m_req();
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0; m_badv = 0;
            model_valid = 1;
        end else begin
            m_cause[15:10] = hwint;
            if (r) begin
                m_sr[1] = 1'b1;
                m_cause[31] = bd_m;
                m_cause[6:2] = i ? 5'd0 : exccode_m;
                m_epc = (pc_m & ~32'd3) - (bd_m ? 32'd4 : 32'd0);
                if (!i && (exccode_m == 5'd4 || exccode_m == 5'd5)) m_badv = badaddr_m;
            end else if (eret_m) begin
                m_sr[1] = 1'b0;
            end else if (we) begin
                if (addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
                else if (addr == 5'd14) m_epc = wdata & ~32'd3;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic peek(input logic [4:0] a, input string name, input logic [31:0] exp);
        addr = a;
        settle();
        check(name, rdata, exp);
        adv();
    endtask

    initial begin
        reset = 1; we = 0; addr = 0; wdata = 0; pc_m = 0; bd_m = 0;
        exccode_m = 0; badaddr_m = 0; hwint = 0; eret_m = 0;
        @(negedge clk);
        step();
        step();
        reset = 0;

        peek(5'd15, "prid", 32'h2017_1205);
        peek(5'd12, "sr_reset", 32'd0);
        peek(5'd13, "cause_reset", 32'd0);
        peek(5'd14, "epc_reset", 32'd0);
        $display("[TB] reset and register map checked");

        we = 1; addr = 12; wdata = 32'h0000_0401;
        step();
        we = 0;
        $display("[TB] mtc0 SR <= 00000401");

        hwint = 6'b000001; pc_m = 32'h0000_3010; bd_m = 0; addr = 14;
        settle();
        check("int_req_same_cycle", {31'd0, exc_req}, 32'd1);
        adv();
        settle();
        check("epc_after_int", rdata, 32'h0000_3010);
        check("no_nest_while_exl", {31'd0, exc_req}, 32'd0);
        adv();
        peek(5'd12, "sr_exl_set", 32'h0000_0403);
        peek(5'd13, "cause_int", 32'h0000_0400);
        $display("[TB] interrupt taken, EPC=00003010");

        eret_m = 1; addr = 14;
        settle();
        check("eret_epc_out", epc_out, 32'h0000_3010);
        adv();
        eret_m = 0;
        settle();
        check("int_refire_after_eret", {31'd0, exc_req}, 32'd1);
        adv();
        hwint = 0; eret_m = 1;
        step();
        eret_m = 0;
        $display("[TB] eret and level-held refire");

        exccode_m = 5'd10; pc_m = 32'h0000_3024; bd_m = 1;
        settle();
        check("exc_same_cycle", {31'd0, exc_req}, 32'd1);
        adv();
        exccode_m = 0; bd_m = 0;
        peek(5'd14, "epc_delay_slot", 32'h0000_3020);
        peek(5'd13, "cause_bd_exc10", 32'h8000_0028);
        eret_m = 1; step(); eret_m = 0;
        $display("[TB] delay-slot exception code 10");

        we = 1; addr = 12; wdata = 32'd0; exccode_m = 5'd12; pc_m = 32'h0000_3100;
        step();
        we = 0; exccode_m = 0;
        peek(5'd12, "sr_write_lost", 32'h0000_0403);
        peek(5'd13, "cause_exc12", 32'h0000_0030);
        eret_m = 1; step(); eret_m = 0;
        $display("[TB] exception beats same-cycle SR write");

        exccode_m = 5'd4; bd_m = 1; pc_m = 32'd0; badaddr_m = 32'h0000_1003;
        step();
        exccode_m = 0; bd_m = 0; badaddr_m = 32'hDEAD_BEEF;
        peek(5'd14, "epc_wrap", 32'hFFFF_FFFC);
`ifdef CP0_BADVADDR_EN
        peek(5'd8, "badvaddr", 32'h0000_1003);
`else
        peek(5'd8, "addr8_absent", 32'd0);
`endif
        eret_m = 1; step(); eret_m = 0;
        $display("[TB] PC wrap and AdEL");

        hwint = 6'b000001; exccode_m = 5'd5; pc_m = 32'h0000_3200; badaddr_m = 32'h0000_2222;
        step();
        exccode_m = 0;
        peek(5'd13, "int_beats_exc", 32'h0000_0400);
`ifdef CP0_BADVADDR_EN
        peek(5'd8, "badvaddr_hold", 32'h0000_1003);
`else
        peek(5'd8, "addr8_absent2", 32'd0);
`endif
        hwint = 0; eret_m = 1; step(); eret_m = 0;
        $display("[TB] interrupt beats AdES");

        we = 1; addr = 14; wdata = 32'h1234_5677;
        settle();
        check("rdw_old_epc", rdata, 32'h0000_3200);
        adv();
        addr = 13; wdata = 32'hFFFF_FFFF;
        step();
        we = 0;
        peek(5'd14, "epc_mtc0", 32'h1234_5674);
        peek(5'd13, "cause_readonly", 32'h0000_0000);
        peek(5'd3, "unmapped", 32'd0);
        $display("[TB] mtc0 EPC and read-only Cause");

        reset = 1; exccode_m = 5'd9; hwint = 6'b111111;
        step();
        reset = 0; exccode_m = 0; hwint = 0;
        peek(5'd14, "epc_rereset", 32'd0);
        peek(5'd12, "sr_rereset", 32'd0);
        $display("[TB] mid-run reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
